// File: rtl/read_miss_issuer.sv
// Read-miss issuer: accepts a tag-lookup miss, pushes it into R_MISS_FIFO,
// then issues one line-aligned AXI AR, tracking outstanding misses.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 4
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

module read_miss_issuer #(
  parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
  parameter int TID_WIDTH  = `TID_WIDTH,
  parameter int ID_WIDTH   = `AXI_ID_WIDTH,
  parameter int MAX_OUTS   = 8,
  parameter int LINE_OFS   = 6
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic [ADDR_WIDTH+TID_WIDTH-1:0]   miss_i,
  output logic                              write_en_o,
  input  logic                              full_i,
  output logic [ADDR_WIDTH+TID_WIDTH-1:0]   wdata_fifo_o,
  output logic                              arvalid_o,
  input  logic                              arready_i,
  output logic [ADDR_WIDTH-1:0]             araddr_o,
  output logic [ID_WIDTH-1:0]               arid_o,
  input  logic                              done_i,
  output logic [$clog2(MAX_OUTS+1)-1:0]     outs_o
);

  localparam int OW = $clog2(MAX_OUTS + 1);
  localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTS);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << LINE_OFS) - ADDR_WIDTH'(1));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PUSH  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t                          state, state_next;
  logic [ADDR_WIDTH+TID_WIDTH-1:0] req_q;
  logic [ID_WIDTH-1:0]             id_q;
  logic [OW-1:0]                   outs_q;
  logic                            rdy;
  logic                            load;
  logic                            push;
  logic                            ar_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    rdy        = 1'b0;
    load       = 1'b0;
    push       = 1'b0;
    ar_hs      = 1'b0;
    arvalid_o  = 1'b0;
    unique case (state)
      S_IDLE: begin
        rdy = (outs_q < MAX_CNT) && !full_i;
        if (valid_i && rdy) begin
          load       = 1'b1;
          state_next = S_PUSH;
        end
      end
      S_PUSH: begin
        if (!full_i) begin
          push       = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        arvalid_o = 1'b1;
        if (arready_i) begin
          ar_hs      = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    req_q <= '0;
    else if (load) req_q <= miss_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     id_q <= '0;
    else if (ar_hs) id_q <= id_q + 1'b1;
  end

  // Simultaneous push and done cancel; done at zero is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outs_q <= '0;
    end else begin
      unique case ({push, done_i})
        2'b10:   outs_q <= outs_q + 1'b1;
        2'b01:   if (outs_q != '0) outs_q <= outs_q - 1'b1;
        default: outs_q <= outs_q;
      endcase
    end
  end

  assign ready_o      = rdy;
  assign write_en_o   = push;
  assign wdata_fifo_o = req_q;
  assign araddr_o     = req_q[ADDR_WIDTH-1:0] & LINE_MASK;
  assign arid_o       = id_q;
  assign outs_o       = outs_q;

endmodule

// File: tb/tb_read_miss_issuer.sv
// Bench for read_miss_issuer: directed scenarios plus a randomized run
// against a transaction-level reference model.
`timescale 1ns/1ps
module tb_read_miss_issuer;
  localparam int AW = 32;
  localparam int TW = 4;
  localparam int IW = 2;
  localparam int MO = 8;
  localparam int LO = 6;
  localparam int OW = $clog2(MO + 1);

  logic            clk;
  logic            rst_n;
  logic            valid_i;
  logic            ready_o;
  logic [AW+TW-1:0] miss_i;
  logic            write_en_o;
  logic            full_i;
  logic [AW+TW-1:0] wdata_fifo_o;
  logic            arvalid_o;
  logic            arready_i;
  logic [AW-1:0]   araddr_o;
  logic [IW-1:0]   arid_o;
  logic            done_i;
  logic [OW-1:0]   outs_o;

  int total = 0;
  int bad   = 0;

  read_miss_issuer #(
    .ADDR_WIDTH(AW),
    .TID_WIDTH (TW),
    .ID_WIDTH  (IW),
    .MAX_OUTS  (MO),
    .LINE_OFS  (LO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .miss_i      (miss_i),
    .write_en_o  (write_en_o),
    .full_i      (full_i),
    .wdata_fifo_o(wdata_fifo_o),
    .arvalid_o   (arvalid_o),
    .arready_i   (arready_i),
    .araddr_o    (araddr_o),
    .arid_o      (arid_o),
    .done_i      (done_i),
    .outs_o      (outs_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid_i = 1'b0; miss_i = '0; full_i = 1'b0;
    arready_i = 1'b0; done_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; valid_i = 1'b0; full_i = 1'b0; arready_i = 1'b0; done_i = 1'b0;
    miss_i = '0;
    drive_point();
    rst_n = 1'b0;
    #1;
    total++; if (write_en_o !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", write_en_o); end
    total++; if (arvalid_o !== 1'b0) begin bad++; $display("FAIL rst_arvalid: got %b want 0", arvalid_o); end
    total++; if (araddr_o !== '0) begin bad++; $display("FAIL rst_araddr: got %h want 0", araddr_o); end
    total++; if (arid_o !== '0) begin bad++; $display("FAIL rst_arid: got %0d want 0", arid_o); end
    total++; if (outs_o !== '0) begin bad++; $display("FAIL rst_outs: got %0d want 0", outs_o); end
    do_reset();
    @(negedge clk);
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready_after: got %b want 1", ready_o); end
  endtask

  task automatic test_single_miss();
    do_reset();
    valid_i = 1'b1; miss_i = {4'd3, 32'h1234_5678}; arready_i = 1'b1;
    @(negedge clk);
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", ready_o); end
    drive_point(); valid_i = 1'b0;
    @(negedge clk);
    total++; if (write_en_o !== 1'b1) begin bad++; $display("FAIL single_we: got %b want 1", write_en_o); end
    total++; if (wdata_fifo_o !== {4'd3, 32'h1234_5678}) begin bad++; $display("FAIL single_wdata: got %h want 312345678", wdata_fifo_o); end
    total++; if (arvalid_o !== 1'b0) begin bad++; $display("FAIL single_early_ar: got %b want 0", arvalid_o); end
    drive_point();
    @(negedge clk);
    total++; if (arvalid_o !== 1'b1) begin bad++; $display("FAIL single_arvalid: got %b want 1", arvalid_o); end
    total++; if (araddr_o !== 32'h1234_5640) begin bad++; $display("FAIL single_araddr: got %h want 12345640", araddr_o); end
    total++; if (arid_o !== 2'd0) begin bad++; $display("FAIL single_arid: got %0d want 0", arid_o); end
    total++; if (outs_o !== 4'd1) begin bad++; $display("FAIL single_outs: got %0d want 1", outs_o); end
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", ready_o); end
    drive_point();
    @(negedge clk);
    total++; if (ready_o !== 1'b1 || arvalid_o !== 1'b0) begin bad++; $display("FAIL single_after: got ready=%b arvalid=%b want 1 0", ready_o, arvalid_o); end
  endtask

  task automatic test_ar_backpressure();
    do_reset();
    valid_i = 1'b1; miss_i = {4'd9, 32'hABCD_EF7F}; arready_i = 1'b0;
    drive_point(); valid_i = 1'b0;
    drive_point();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) arready_i = 1'b1;
      @(negedge clk);
      total++;
      if (arvalid_o !== 1'b1 || araddr_o !== 32'hABCD_EF40 || arid_o !== 2'd0 || ready_o !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got arvalid=%b araddr=%h arid=%0d ready=%b want 1 abcdef40 0 0",
                 i, arvalid_o, araddr_o, arid_o, ready_o);
      end
      drive_point();
    end
    arready_i = 1'b0;
    @(negedge clk);
    total++; if (arvalid_o !== 1'b0 || ready_o !== 1'b1) begin bad++; $display("FAIL bp_single_hs: got arvalid=%b ready=%b want 0 1", arvalid_o, ready_o); end
    total++; if (arid_o !== 2'd1) begin bad++; $display("FAIL bp_id_inc: got %0d want 1", arid_o); end
  endtask

  task automatic test_fifo_full();
    int pushes;
    pushes = 0;
    do_reset();
    valid_i = 1'b1; miss_i = {4'd5, 32'h0000_1FFF}; arready_i = 1'b0;
    drive_point(); valid_i = 1'b0; full_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (write_en_o !== 1'b0 || arvalid_o !== 1'b0) begin
        bad++; $display("FAIL full_hold[%0d]: got we=%b arvalid=%b want 0 0", i, write_en_o, arvalid_o);
      end
      drive_point();
    end
    full_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (write_en_o === 1'b1) pushes++;
      drive_point();
    end
    total++; if (pushes != 1) begin bad++; $display("FAIL full_pushes: got %0d want 1", pushes); end
    @(negedge clk);
    total++; if (arvalid_o !== 1'b1 || araddr_o !== 32'h0000_1FC0) begin bad++; $display("FAIL full_ar: got arvalid=%b araddr=%h want 1 00001fc0", arvalid_o, araddr_o); end
  endtask

  task automatic test_outs_limit_and_id_wrap();
    do_reset();
    arready_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      valid_i = 1'b1; miss_i = {4'(i), $urandom()};
      if (i == 8) begin
        @(negedge clk);
        total++; if (ready_o !== 1'b0 || outs_o !== 4'd8) begin bad++; $display("FAIL lim_block: got ready=%b outs=%0d want 0 8", ready_o, outs_o); end
        drive_point(); valid_i = 1'b0;
        @(negedge clk);
        total++; if (write_en_o !== 1'b0) begin bad++; $display("FAIL lim_no_push: got %b want 0", write_en_o); end
        break;
      end
      drive_point(); valid_i = 1'b0;
      drive_point();
      @(negedge clk);
      if (i < 5) begin
        total++; if (arid_o !== 2'(i % 4)) begin bad++; $display("FAIL id_seq[%0d]: got %0d want %0d", i, arid_o, i % 4); end
      end
      drive_point();
    end
    drive_point(); done_i = 1'b1;
    drive_point(); done_i = 1'b0; valid_i = 1'b1; miss_i = {4'hE, 32'h8000_00C1};
    @(negedge clk);
    total++; if (outs_o !== 4'd7 || ready_o !== 1'b1) begin bad++; $display("FAIL lim_done: got outs=%0d ready=%b want 7 1", outs_o, ready_o); end
    drive_point(); valid_i = 1'b0; done_i = 1'b1;
    @(negedge clk);
    total++; if (write_en_o !== 1'b1) begin bad++; $display("FAIL lim_push: got %b want 1", write_en_o); end
    drive_point(); done_i = 1'b0;
    @(negedge clk);
    total++; if (outs_o !== 4'd7) begin bad++; $display("FAIL lim_cancel: got outs=%0d want 7", outs_o); end
    total++; if (arid_o !== 2'd0 || araddr_o !== 32'h8000_00C0) begin bad++; $display("FAIL lim_ar9: got arid=%0d araddr=%h want 0 800000c0", arid_o, araddr_o); end
  endtask

  task automatic test_reset_mid_txn();
    do_reset();
    valid_i = 1'b1; miss_i = {4'd1, 32'h0000_0100}; arready_i = 1'b0;
    drive_point(); valid_i = 1'b0;
    drive_point();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++; if (arvalid_o !== 1'b0 || write_en_o !== 1'b0 || araddr_o !== '0 || arid_o !== '0 || outs_o !== '0) begin
      bad++; $display("FAIL mid_issue_rst: got arvalid=%b we=%b araddr=%h arid=%0d outs=%0d want all 0",
                      arvalid_o, write_en_o, araddr_o, arid_o, outs_o);
    end
    drive_point(); rst_n = 1'b1; arready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (arvalid_o !== 1'b0 || write_en_o !== 1'b0 || outs_o !== '0) begin
        bad++; $display("FAIL mid_issue_after[%0d]: got arvalid=%b we=%b outs=%0d want 0 0 0", i, arvalid_o, write_en_o, outs_o);
      end
      drive_point();
    end
    valid_i = 1'b1; miss_i = {4'd2, 32'h0000_0200};
    drive_point(); valid_i = 1'b0; full_i = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b0;
    drive_point(); rst_n = 1'b1; full_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (arvalid_o !== 1'b0 || write_en_o !== 1'b0) begin
        bad++; $display("FAIL mid_push_after[%0d]: got arvalid=%b we=%b want 0 0", i, arvalid_o, write_en_o);
      end
      drive_point();
    end
  endtask

  // Model: at most one miss in flight; it is pushed first, then issued.
  task automatic test_random();
    bit             busy, pushed;
    logic [AW+TW-1:0] cur;
    int             outs, next_id;
    bit             e_rdy, e_we, e_arv;
    logic [AW-1:0]  e_addr;
    busy = 0; pushed = 0; cur = '0; outs = 0; next_id = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      valid_i   = ($urandom_range(0, 1) == 1);
      full_i    = ($urandom_range(0, 3) == 0);
      arready_i = ($urandom_range(0, 1) == 1);
      done_i    = ($urandom_range(0, 4) == 0);
      miss_i    = {4'($urandom()), $urandom()};
      @(negedge clk);
      e_rdy = !busy && outs < MO && !full_i;
      e_we  = busy && !pushed && !full_i;
      e_arv = busy && pushed;
      e_addr = cur[AW-1:0];
      e_addr[LO-1:0] = '0;
      total++; if (ready_o !== e_rdy) begin bad++; $display("FAIL rnd_ready@%0d: got %b want %b", c, ready_o, e_rdy); end
      total++; if (write_en_o !== e_we) begin bad++; $display("FAIL rnd_we@%0d: got %b want %b", c, write_en_o, e_we); end
      total++; if (arvalid_o !== e_arv) begin bad++; $display("FAIL rnd_arvalid@%0d: got %b want %b", c, arvalid_o, e_arv); end
      total++; if (outs_o !== OW'(outs)) begin bad++; $display("FAIL rnd_outs@%0d: got %0d want %0d", c, outs_o, outs); end
      if (e_we) begin
        total++; if (wdata_fifo_o !== cur) begin bad++; $display("FAIL rnd_wdata@%0d: got %h want %h", c, wdata_fifo_o, cur); end
      end
      if (e_arv) begin
        total++; if (araddr_o !== e_addr || arid_o !== IW'(next_id)) begin
          bad++; $display("FAIL rnd_ar@%0d: got addr=%h id=%0d want %h %0d", c, araddr_o, arid_o, e_addr, next_id);
        end
      end
      if (e_we && done_i)      outs = outs;
      else if (e_we)           outs = outs + 1;
      else if (done_i && outs > 0) outs = outs - 1;
      if (e_rdy && valid_i) begin busy = 1; pushed = 0; cur = miss_i; end
      if (e_we) pushed = 1;
      if (e_arv && arready_i) begin busy = 0; next_id = (next_id + 1) % (1 << IW); end
      drive_point();
    end
    valid_i = 1'b0; done_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_ar_backpressure();
    test_fifo_full();
    test_outs_limit_and_id_wrap();
    test_reset_mid_txn();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/read_miss_issuer.md
READ_MISS_ISSUER -- requirements
Module: read_miss_issuer

Interface
REQ-001 Parameters (name, default, meaning): ADDR_WIDTH, `AXI_ADDR_WIDTH, request address width; TID_WIDTH, `TID_WIDTH, transaction tag width; ID_WIDTH, `AXI_ID_WIDTH, AXI ARID width; MAX_OUTS, 8, maximum outstanding misses; LINE_OFS, 6, cache-line offset bits cleared on ARADDR.
REQ-002 Single clock; reset is asynchronous and active-low. Ports: clk input 1, clock; rst_n input 1, asynchronous active-low reset.
REQ-003 valid_i input 1, a read-miss request is present from the tag lookup.
REQ-004 ready_o output 1, this block accepts the request this cycle.
REQ-005 miss_i input ADDR_WIDTH+TID_WIDTH, {tid, addr}, with addr in [ADDR_WIDTH-1:0].
REQ-006 write_en_o output 1, push one entry into R_MISS_FIFO.
REQ-007 full_i input 1, R_MISS_FIFO is full.
REQ-008 wdata_fifo_o output ADDR_WIDTH+TID_WIDTH, FIFO entry {tid, addr}, unmodified from miss_i.
REQ-009 arvalid_o output 1, AXI read-address valid toward the CXL controller.
REQ-010 arready_i input 1, AXI read-address ready from the CXL controller.
REQ-011 araddr_o output ADDR_WIDTH, line-aligned read address.
REQ-012 arid_o output ID_WIDTH, read ID.
REQ-013 done_i input 1, single-cycle pulse when the read-miss handler pops one FIFO entry.
REQ-014 outs_o output $clog2(MAX_OUTS+1), current outstanding count.

Function
REQ-015 The FSM SHALL have states S_IDLE, S_PUSH and S_ISSUE, and SHALL reset to S_IDLE.
REQ-016 ready_o SHALL be 1 only in S_IDLE with outs_o < MAX_OUTS and full_i = 0; otherwise it is 0 (combinational).
REQ-017 In S_IDLE, valid_i & ready_o SHALL register miss_i into the request register and move the FSM to S_PUSH.
REQ-018 In S_PUSH, write_en_o SHALL be 1 for exactly one cycle when full_i = 0, after which the FSM moves to S_ISSUE; while full_i = 1, the FSM holds in S_PUSH with write_en_o = 0.
REQ-019 In S_ISSUE, arvalid_o SHALL be 1, and araddr_o and arid_o SHALL be stable until arvalid_o & arready_i; on that handshake, the FSM moves to S_IDLE.
REQ-020 araddr_o SHALL equal the registered addr with bits [LINE_OFS-1:0] forced to 0.
REQ-021 arid_o SHALL come from a free-running ID counter that increments by 1 on each AR handshake and wraps from 2^ID_WIDTH-1 to 0.
REQ-022 The minimum latency SHALL be: accept at cycle T, write_en_o at T+1, arvalid_o from T+2, and ready_o again at the cycle after the handshake.
REQ-023 The outstanding counter SHALL increment on each FIFO push (write_en_o = 1) and decrement on done_i; when both occur in the same cycle, it SHALL stay unchanged.
REQ-024 done_i at count 0 SHALL be ignored, with no underflow; a push at count MAX_OUTS cannot occur because of REQ-016.
REQ-025 valid_i while ready_o = 0 SHALL have no effect; miss_i is not sampled.
REQ-026 The FIFO entry SHALL always be pushed before the matching AR, so a response can never precede its FIFO entry.

Reset
REQ-027 While rst_n = 0, asynchronously: state = S_IDLE; the request register, ID counter and outstanding counter = 0; write_en_o = 0, arvalid_o = 0, araddr_o = 0, arid_o = 0, outs_o = 0.
REQ-028 Reset asserted in S_PUSH or S_ISSUE SHALL abandon the request with no FIFO push and no AR after release.
REQ-029 The first cycle after release SHALL have ready_o = 1 if full_i = 0.

Verification
REQ-030 Single miss: miss_i = {tid 3, addr 0x1234_5678}, arready_i = 1 -> write_en_o at T+1 with wdata {3, 0x1234_5678}; arvalid_o at T+2 with araddr 0x1234_5640, arid 0; outs_o = 1.
REQ-031 AR backpressure: arready_i = 0 for 5 cycles -> arvalid_o, araddr_o and arid_o held for 6 cycles, then a single handshake; ready_o = 0 throughout.
REQ-032 FIFO full: full_i = 1 in S_PUSH for 3 cycles -> write_en_o = 0 and no arvalid_o until full_i = 0, then exactly one push.
REQ-033 Outstanding limit: 8 misses with no done_i -> ready_o = 0 after the 8th; one done_i pulse -> outs_o = 7 and ready_o = 1 next cycle; a push and done_i in the same cycle -> outs_o unchanged.
REQ-034 ID wrap: with ID_WIDTH = 2, 5 misses -> arid_o sequence 0, 1, 2, 3, 0.
REQ-035 Reset mid-issue: rst_n low while arvalid_o = 1 -> all outputs 0 immediately; after release, no AR and outs_o = 0.
